// File: rtl/rca_nibble_sequencer.sv
// Purpose : drives an external 4-bit ripple-carry adder one nibble per cycle (LSB first) to build a WIDTH-bit sum.
// Latency : operands accepted at edge E, result valid after edge E+NIBBLES; next acceptance no sooner than NIBBLES+2 cycles.
// Backpr. : in_ready only in IDLE; result held in DONE until out_ready, with in_valid ignored meanwhile.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready, op_a/op_b/op_cin     operand handshake
//   add_a/add_b/add_cin -> adder, add_sum/add_cout <- adder (combinational, same cycle)
//   out_valid/out_ready, out_sum/out_cout/out_ovf   result handshake
//   busy                          high whenever not IDLE
module rca_nibble_sequencer #(
  parameter int WIDTH = 16,              // multiple of 4, >= 4
  localparam int NIBBLES = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q;
  logic [NIBBLES-1:0][3:0] a_q, b_q, res_q, res_d;
  logic                    carry_q;
  logic [IDXW-1:0]         idx_q;
  logic [WIDTH-1:0]        out_sum_q;
  logic                    out_cout_q, out_ovf_q, out_valid_q;
  logic                    msb_a, msb_b;

  assign msb_a = a_q[NIBBLES-1][3];
  assign msb_b = b_q[NIBBLES-1][3];

  // Partial result with the nibble being computed this cycle merged in, so the
  // final edge can publish the full sum without an extra cycle.
  always_comb begin
    res_d        = res_q;
    res_d[idx_q] = add_sum;
  end

  // Adder inputs are only live during ADD; quiet otherwise.
  always_comb begin
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if (state_q == ADD) begin
      add_a   = a_q[idx_q];
      add_b   = b_q[idx_q];
      add_cin = carry_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= op_a;
            b_q     <= op_b;
            carry_q <= op_cin;
            idx_q   <= '0;
            state_q <= ADD;
          end
        end
        ADD: begin
          res_q   <= res_d;
          carry_q <= add_cout;
          if (idx_q == LAST_IDX) begin
            idx_q       <= '0;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_sum_q   <= res_d;
            out_cout_q  <= add_cout;
            // Same-sign operands yielding an opposite-sign result.
            out_ovf_q   <= (msb_a == msb_b) && (add_sum[3] != msb_a);
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// Purpose : exercises rca_nibble_sequencer (WIDTH=16) with a behavioural 4-bit adder attached.
// Latency : checks result appears exactly NIBBLES edges after acceptance and back-to-back spacing.
// Backpr. : holds out_ready low to confirm result stability and that in_valid is ignored.
module tb_rca_nibble_sequencer;

  localparam int W  = 16;
  localparam int NB = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         op_cin = 1'b0;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout, out_ovf, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // The external ripple-carry adder, modelled as plain arithmetic.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

  rca_nibble_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] ref_full(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0] s;
    s = ref_full(a, b, cin);
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  // Carry entering nibble i = carry out of the low 4*i bits of the full sum.
  function automatic logic ref_cin_at(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input int i);
    longint unsigned m, lo;
    if (i == 0) return cin;
    m  = (64'd1 << (4 * i)) - 1;
    lo = (longint'(a) & m) + (longint'(b) & m) + longint'(cin);
    return lo[4 * i];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; hold = cycles out_ready stays low once the result is up.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input int hold);
    logic [W:0]   exp;
    logic [W-1:0] snap;
    int           waited;
    exp = ref_full(a, b, cin);
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) chk("rdy_timeout", 32'(in_ready), 32'd1);
    op_a = a; op_b = b; op_cin = cin; in_valid = 1'b1;
    tick();                                   // acceptance edge
    in_valid = 1'b0;
    chk("add_busy", {30'd0, busy, in_ready}, 32'b10);
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("add_a[%0d]", i), 32'(add_a), 32'((a >> (4 * i)) & 4'hF));
      chk($sformatf("add_b[%0d]", i), 32'(add_b), 32'((b >> (4 * i)) & 4'hF));
      chk($sformatf("add_cin[%0d]", i), 32'(add_cin), 32'(ref_cin_at(a, b, cin, i)));
      chk($sformatf("early_vld[%0d]", i), 32'(out_valid), 32'd0);
      tick();
    end
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_sum", 32'(out_sum), 32'(exp[W-1:0]));
    chk("out_cout", 32'(out_cout), 32'(exp[W]));
    chk("out_ovf", 32'(out_ovf), 32'(ref_ovf(a, b, cin)));
    chk("done_add_idle", {27'd0, add_a, add_cin}, 32'd0);
    snap = out_sum;
    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin
        op_a = ~a; op_b = 16'h1111; in_valid = 1'b1;   // must be ignored
      end else begin
        in_valid = 1'b0;
      end
      tick();
      chk("hold_vld", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'(out_sum), 32'(snap));
      chk("hold_rdy", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("handoff_vld", 32'(out_valid), 32'd0);
    chk("handoff_rdy", {30'd0, in_ready, busy}, 32'b10);
    tick();
    chk("no_capture", 32'(busy), 32'd0);
  endtask

  initial begin : main
    logic [W-1:0] ba [3];
    logic [W-1:0] bb [3];
    logic         bc [3];
    logic [W:0]   e;
    int n_acc, n_done, last_cyc, cyc;
    logic was_ready;

    // Reset state
    #2;
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_vld_busy", {30'd0, out_valid, busy}, 32'd0);
    chk("rst_outs", {14'd0, out_sum, out_cout, out_ovf}, 32'd0);
    chk("rst_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Directed cases
    run_op(16'h1234, 16'h4321, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 0);
    run_op(16'hABCD, 16'h1357, 1'b1, 6);      // backpressure window

    // Reset during the second ADD cycle
    op_a = 16'hF0F0; op_b = 16'h0F0F; op_cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("arst_busy_vld", {30'd0, busy, out_valid}, 32'd0);
    chk("arst_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
    chk("arst_rdy", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_rdy", 32'(in_ready), 32'd1);
    run_op(16'h0010, 16'h0020, 1'b0, 0);

    // Randomized single operations with random backpressure
    for (int k = 0; k < 20; k++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    // Back-to-back with in_valid and out_ready held high
    for (int k = 0; k < 3; k++) begin
      ba[k] = W'($urandom); bb[k] = W'($urandom); bc[k] = 1'($urandom);
    end
    n_acc = 0; n_done = 0; last_cyc = -1; cyc = 0;
    op_a = ba[0]; op_b = bb[0]; op_cin = bc[0];
    in_valid = 1'b1; out_ready = 1'b1;
    was_ready = in_ready;
    while (n_done < 3 && cyc < 60) begin
      tick();
      cyc++;
      if (was_ready && in_valid) begin
        n_acc++;
        if (n_acc < 3) begin
          op_a = ba[n_acc]; op_b = bb[n_acc]; op_cin = bc[n_acc];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        e = ref_full(ba[n_done], bb[n_done], bc[n_done]);
        chk("b2b_sum", 32'(out_sum), 32'(e[W-1:0]));
        chk("b2b_cout", 32'(out_cout), 32'(e[W]));
        chk("b2b_ovf", 32'(out_ovf), 32'(ref_ovf(ba[n_done], bb[n_done], bc[n_done])));
        if (last_cyc >= 0) chk("b2b_spacing", 32'(cyc - last_cyc), 32'(NB + 2));
        last_cyc = cyc;
        n_done++;
      end
      was_ready = in_ready;
    end
    chk("b2b_count", 32'(n_done), 32'd3);
    in_valid = 1'b0; out_ready = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
